// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end for the 1101 sequence detector.
// A one-word holding register lets consecutive words stream with no idle bit between them.
module seq_bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] shreg;
  logic             hold_full;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             load;
  logic             last_bit;

  assign accept   = s_valid && !hold_full;
  assign last_bit = (state == SHIFT) && (cnt == LAST);

  // A held word moves into the shifter either from idle or right after the last bit, so words chain gap-free
  always_comb begin
    state_n = state;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          load    = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          if (hold_full) load = 1'b1;
          else           state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Accept and transfer never coincide: accept needs hold empty, transfer needs it full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      if (accept) hold <= s_data;
      if (load)        hold_full <= 1'b0;
      else if (accept) hold_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= hold;
      cnt   <= '0;
    end else if (last_bit) begin
      cnt   <= '0;
    end else if (state == SHIFT) begin
      shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
      cnt   <= cnt + 1'b1;
    end
  end

  assign s_ready   = !hold_full;
  assign ser_valid = (state == SHIFT);
  assign ser_out   = (state == SHIFT) ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : IDLE_LEVEL;
  assign busy      = (state == SHIFT) || hold_full;
  assign word_done = last_bit;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: two instances (MSB-first/idle-0, LSB-first/idle-1) share one stimulus;
// a queue of expected serial bits is filled on accept and drained by a cycle monitor.
module tb_seq_bit_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       ready_a, out_a, valid_a, busy_a, done_a;
  logic       ready_b, out_b, valid_b, busy_b, done_b;

  int asserts = 0;
  int fails   = 0;

  typedef struct {
    bit ba;
    bit bb;
    bit first;
    bit last;
  } exp_t;

  exp_t q[$];
  exp_t e;
  bit   gap_now = 1'b0;
  bit   exp_valid;
  bit   exp_busy;
  bit   exp_ready;
  int   nfirst;

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(ready_a),
    .ser_out(out_a), .ser_valid(valid_a), .busy(busy_a), .word_done(done_a)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(ready_b),
    .ser_out(out_b), .ser_valid(valid_b), .busy(busy_b), .word_done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    asserts++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    asserts++;
    fails++;
    $display("[TB] FAIL %s: timed out at %0t", name, $time);
  endtask

  // Expected stream: word bits in transmission order for each bit-order variant
  task automatic pushWord(input logic [7:0] w);
    exp_t x;
    for (int i = 0; i < 8; i++) begin
      x.ba    = w[7-i];
      x.bb    = w[i];
      x.first = (i == 0);
      x.last  = (i == 7);
      q.push_back(x);
    end
  endtask

  // Cycle monitor: the model predicts valid/busy/ready from what is still owed downstream
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_ready_a", ready_a, 1'b1);
      checkOutput("rst_ready_b", ready_b, 1'b1);
      checkOutput("rst_valid_a", valid_a, 1'b0);
      checkOutput("rst_valid_b", valid_b, 1'b0);
      checkOutput("rst_busy_a", busy_a, 1'b0);
      checkOutput("rst_out_a", out_a, 1'b0);
      checkOutput("rst_out_b", out_b, 1'b1);
      checkOutput("rst_done_a", done_a, 1'b0);
      q.delete();
      gap_now = 1'b0;
    end else begin
      exp_valid = (q.size() > 0) && !gap_now;
      exp_busy  = (q.size() > 0);
      checkOutput("ser_valid_a", valid_a, exp_valid);
      checkOutput("ser_valid_b", valid_b, exp_valid);
      checkOutput("busy_a", busy_a, exp_busy);
      checkOutput("busy_b", busy_b, exp_busy);
      if (exp_valid) begin
        e = q.pop_front();
        checkOutput("ser_out_a", out_a, e.ba);
        checkOutput("ser_out_b", out_b, e.bb);
        checkOutput("word_done_a", done_a, e.last);
        checkOutput("word_done_b", done_b, e.last);
      end else begin
        checkOutput("idle_out_a", out_a, 1'b0);
        checkOutput("idle_out_b", out_b, 1'b1);
        checkOutput("idle_done_a", done_a, 1'b0);
      end
      nfirst = 0;
      foreach (q[i]) if (q[i].first) nfirst++;
      exp_ready = (nfirst == 0);
      checkOutput("s_ready_a", ready_a, exp_ready);
      checkOutput("s_ready_b", ready_b, exp_ready);
      if (s_valid && exp_ready) begin
        gap_now = (q.size() == 0);
        pushWord(s_data);
      end else begin
        gap_now = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] w);
    int n = 0;
    s_data  = w;
    s_valid = 1'b1;
    @(negedge clk);
    while (!ready_a && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!ready_a) reportTimeout("accept_wait");
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((q.size() > 0) && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (q.size() > 0) reportTimeout("drain_wait");
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] single word");
    applyStimulus(8'hDA);
    waitDrain();

    $display("[TB] back-to-back across boundary");
    applyStimulus(8'h03);
    applyStimulus(8'h40);
    waitDrain();

    $display("[TB] backpressure with three words");
    applyStimulus(8'hA5);
    applyStimulus(8'h3C);
    applyStimulus(8'hE1);
    waitDrain();

    $display("[TB] bit order word");
    applyStimulus(8'h0B);
    waitDrain();

    $display("[TB] reset mid-word");
    applyStimulus(8'hFF);
    applyStimulus(8'h55);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("async_valid_a", valid_a, 1'b0);
    checkOutput("async_busy_a", busy_a, 1'b0);
    checkOutput("async_busy_b", busy_b, 1'b0);
    checkOutput("async_out_a", out_a, 1'b0);
    checkOutput("async_out_b", out_b, 1'b1);
    checkOutput("async_ready_a", ready_a, 1'b1);
    checkOutput("async_done_a", done_a, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(8'h96);
    waitDrain();

    $display("[TB] idle gap between words");
    applyStimulus(8'hD0);
    waitDrain();
    repeat (5) @(posedge clk);
    #1;
    applyStimulus(8'h0D);
    waitDrain();

    $display("[TB] random traffic");
    repeat (30) begin
      int gap;
      gap = $urandom_range(0, 9);
      repeat (gap) begin
        @(posedge clk);
        #1 s_data = 8'($urandom);
      end
      applyStimulus(8'($urandom));
    end
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/seq_bit_serializer.md
# seq_bit_serializer

Parallel-to-serial front end for the 1101 sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `ser_out`, which drives the detector's `in` port directly. A one-word holding register lets consecutive words stream with no idle bit between them, so patterns that straddle a word boundary (e.g. "11" | "01") reach the detector intact.

## Interface
- `WIDTH`, 8: bits per word; legal range 2..32.
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 first.
- `IDLE_LEVEL`, 0: value driven on `ser_out` when no word is being shifted.

- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset; clears all state immediately.
- `s_data`  in  WIDTH  word to serialize; sampled when `s_valid && s_ready`.
- `s_valid`  in  1  upstream has a word.
- `s_ready`  out  1  holding register empty; a word is accepted on any edge where `s_valid && s_ready`.
- `ser_out`  out  1  serial bit to detector `in`.
- `ser_valid`  out  1  `ser_out` carries a data bit this cycle.
- `busy`  out  1  shifter or holding register occupied.
- `word_done`  out  1  high during the cycle the last bit of a word is on `ser_out`.

## Operation
- Storage: holding register `hold` plus `hold_full` flag; shift register `shreg`; bit counter `cnt` (0..WIDTH-1); state IDLE/SHIFT.
- `s_ready = !hold_full`. Accepted word is written to `hold` and sets `hold_full`.
- IDLE: `ser_valid=0`, `ser_out=IDLE_LEVEL`. If `hold_full`, next edge: `shreg<=hold`, `hold_full<=0`, `cnt<=0`, go SHIFT.
- SHIFT: `ser_out` = current first-order bit of `shreg` (MSB or LSB per `MSB_FIRST`), `ser_valid=1`. Each edge with `cnt<WIDTH-1`: shift `shreg` one position, `cnt<=cnt+1`.
- SHIFT with `cnt==WIDTH-1` (`word_done=1`): if `hold_full`, reload from `hold`, `cnt<=0`, stay SHIFT (no gap); else go IDLE.
- `hold_full` clears on the edge it transfers into `shreg`; no accept can occur on that same edge because `s_ready` was 0, so there is no simultaneous load/store conflict.
- `busy = (state==SHIFT) || hold_full`.
- `s_data` is ignored when not accepted; `s_valid` dropping without acceptance has no effect.
- Bits are never reordered, dropped or duplicated between accepts and `ser_out`.

## Timing
- Reset values (while `rst` high and until the first edge after release): `s_ready=1`, `ser_valid=0`, `ser_out=IDLE_LEVEL`, `busy=0`, `word_done=0`, state IDLE, `cnt=0`, `hold_full=0`.
- Latency: word accepted at edge E0 with serializer idle → first bit valid in the cycle after E1, last bit in the cycle after E(WIDTH).
- Throughput: one word per WIDTH cycles sustained; `s_ready` reasserts the cycle after hold→shreg transfer, leaving WIDTH-1 cycles to refill before the next reload.
- Back-to-back: if hold is full when `word_done`, the next word's first bit follows on the very next cycle; `ser_valid` stays continuously high.
- Reset mid-word: asynchronous clear; the partial word and any held word are discarded, `ser_out` returns to `IDLE_LEVEL` without waiting for a clock.
- All outputs are decoded from registers only; there is no combinational path from `s_valid`/`s_data` to any output.

## Test plan
- WIDTH=8, MSB_FIRST=1: accept 8'hDA once → `ser_out` 1,1,0,1,1,0,1,0 on 8 consecutive `ser_valid` cycles starting 2 edges after accept; `word_done` only on the 8th; downstream detector `out` pulses after bits 4 and 7.
- Back-to-back 8'h03 then 8'h40 with `s_valid` held high → 16 contiguous `ser_valid` cycles, stream 0000_0011_0100_0000; detector fires once across the boundary ("1101" at bits 7-10).
- Backpressure: hold `s_valid=1` with three words while serializer busy → `s_ready` low while `hold_full`; each word accepted exactly once, output order preserved, no gaps.
- MSB_FIRST=0, accept 8'h0B → `ser_out` 1,1,0,1,0,0,0,0.
- Assert `rst` during bit 4 of 8'hFF with a second word held → `ser_valid`, `busy` drop immediately, `ser_out=IDLE_LEVEL`, `s_ready=1`; after release, a fresh word serializes normally.
- Idle gap: accept 8'hD0, wait 5 cycles, accept 8'h0D → `ser_out=IDLE_LEVEL` and `ser_valid=0` between words; `busy` low during the gap.
